// File: rtl/grade_guess_engine_if.sv
// Player-facing bundle for the grading engine: game control, master pattern, guess and results.
// master drives requests and patterns; slave is the engine.
interface grade_guess_engine_if;
    logic        startGame;
    logic        masterLoaded;
    logic [11:0] masterPattern;
    logic        gradeIt;
    logic [11:0] guess;
    logic        busy;
    logic        done;
    logic        badGuess;
    logic [2:0]  znarly;
    logic [2:0]  zood;
    logic [3:0]  roundNumber;
    logic        gameWon;
    logic        gameOver;

    modport master (
        output startGame, masterLoaded, masterPattern, gradeIt, guess,
        input  busy, done, badGuess, znarly, zood, roundNumber, gameWon, gameOver
    );

    modport slave (
        input  startGame, masterLoaded, masterPattern, gradeIt, guess,
        output busy, done, badGuess, znarly, zood, roundNumber, gameWon, gameOver
    );
endinterface

// File: rtl/grade_guess_engine.sv
// Grades a 4-slot guess against the loaded master: exact (znarly) and shape-only (zood) matches.
// Latency: request accepted at edge E, results and done pulse visible after edge E+11.
// No queueing: requests while busy, game over or master not loaded are dropped.
module grade_guess_engine #(
    parameter int SLOTS      = 4,
    parameter int SHAPE_W    = 3,
    parameter int NUM_SHAPES = 6,
    parameter int MAX_ROUNDS = 8
) (
    input logic               clock,
    input logic               reset,
    grade_guess_engine_if.slave gg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXACT = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0]         LAST_SLOT  = 3'(SLOTS - 1);
    localparam logic [2:0]         LAST_SHAPE = 3'(NUM_SHAPES);
    localparam logic [3:0]         LAST_ROUND = 4'(MAX_ROUNDS);
    localparam logic [SHAPE_W-1:0] SHAPE_NONE = '0;
    localparam logic [SHAPE_W-1:0] SHAPE_ALL1 = '1;

    logic [1:0]  state;
    logic [2:0]  step;
    logic [11:0] g_cap;
    logic [11:0] m_cap;
    logic [2:0]  exact_acc;
    logic [2:0]  total_acc;

    logic        guess_ok;
    logic        slot_hit;
    logic [2:0]  cnt_m;
    logic [2:0]  cnt_g;
    logic [2:0]  shape_min;
    logic        accept;

    always_comb begin
        guess_ok = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            if (gg.guess[i*SHAPE_W +: SHAPE_W] == SHAPE_NONE ||
                gg.guess[i*SHAPE_W +: SHAPE_W] == SHAPE_ALL1)
                guess_ok = 1'b0;
        end
    end

    assign slot_hit = (g_cap[step[1:0]*SHAPE_W +: SHAPE_W] == m_cap[step[1:0]*SHAPE_W +: SHAPE_W]);

    // Per-shape occurrence counts on the captured copies; step holds the shape code in COUNT.
    always_comb begin
        cnt_m = '0;
        cnt_g = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cnt_m = cnt_m + {2'b00, (m_cap[i*SHAPE_W +: SHAPE_W] == step)};
            cnt_g = cnt_g + {2'b00, (g_cap[i*SHAPE_W +: SHAPE_W] == step)};
        end
        shape_min = (cnt_m < cnt_g) ? cnt_m : cnt_g;
    end

    assign accept = (state == IDLE) && gg.gradeIt && gg.masterLoaded && !gg.gameOver;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            step           <= '0;
            g_cap          <= '0;
            m_cap          <= '0;
            exact_acc      <= '0;
            total_acc      <= '0;
            gg.busy        <= 1'b0;
            gg.done        <= 1'b0;
            gg.badGuess    <= 1'b0;
            gg.znarly      <= '0;
            gg.zood        <= '0;
            gg.roundNumber <= '0;
            gg.gameWon     <= 1'b0;
            gg.gameOver    <= 1'b0;
        end else if (gg.startGame) begin
            state          <= IDLE;
            step           <= '0;
            gg.busy        <= 1'b0;
            gg.done        <= 1'b0;
            gg.badGuess    <= 1'b0;
            gg.znarly      <= '0;
            gg.zood        <= '0;
            gg.roundNumber <= '0;
            gg.gameWon     <= 1'b0;
            gg.gameOver    <= 1'b0;
        end else begin
            gg.done     <= 1'b0;
            gg.badGuess <= 1'b0;
            // busy covers the done cycle, so it drops together with done
            if (gg.done)
                gg.busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!guess_ok) begin
                            gg.badGuess <= 1'b1;
                        end else begin
                            g_cap     <= gg.guess;
                            m_cap     <= gg.masterPattern;
                            exact_acc <= '0;
                            total_acc <= '0;
                            step      <= '0;
                            gg.busy   <= 1'b1;
                            state     <= EXACT;
                        end
                    end
                end
                EXACT: begin
                    exact_acc <= exact_acc + {2'b00, slot_hit};
                    if (step == LAST_SLOT) begin
                        step  <= 3'd1;
                        state <= COUNT;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                COUNT: begin
                    total_acc <= total_acc + shape_min;
                    if (step == LAST_SHAPE)
                        state <= DONE;
                    else
                        step <= step + 3'd1;
                end
                DONE: begin
                    gg.znarly      <= exact_acc;
                    gg.zood        <= total_acc - exact_acc;
                    gg.roundNumber <= gg.roundNumber + 4'd1;
                    gg.gameWon     <= gg.gameWon | (exact_acc == 3'd4);
                    gg.gameOver    <= gg.gameOver | (exact_acc == 3'd4) |
                                      (gg.roundNumber + 4'd1 == LAST_ROUND);
                    gg.done        <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grade_guess_engine.sv
// Randomized self-checking bench for grade_guess_engine against a counting reference model.
module tb_grade_guess_engine;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [2:0] m_z, m_zd;
    logic [3:0] m_round;
    logic       m_won, m_over;

    grade_guess_engine_if gg ();

    grade_guess_engine dut (
        .clock (clock),
        .reset (reset),
        .gg    (gg)
    );

    always #5 clock = ~clock;

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    function automatic void model_grade(input logic [11:0] m, input logic [11:0] g,
                                        output logic [2:0] z, output logic [2:0] zd);
        int cm[8] = '{default: 0};
        int cg[8] = '{default: 0};
        int e = 0;
        int t = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[3*i +: 3] == g[3*i +: 3]) e++;
            cm[m[3*i +: 3]]++;
            cg[g[3*i +: 3]]++;
        end
        for (int s = 1; s <= 6; s++) t += (cm[s] < cg[s]) ? cm[s] : cg[s];
        z  = 3'(e);
        zd = 3'(t - e);
    endfunction

    function automatic logic [11:0] rand_legal();
        logic [11:0] p;
        for (int i = 0; i < 4; i++) p[3*i +: 3] = 3'($urandom_range(1, 6));
        return p;
    endfunction

    function automatic logic [11:0] non_winning(input logic [11:0] m);
        logic [11:0] g = rand_legal();
        if (g == m) g[2:0] = (m[2:0] == 3'd6) ? 3'd1 : m[2:0] + 3'd1;
        return g;
    endfunction

    task automatic model_clear;
        m_z = 0; m_zd = 0; m_round = 0; m_won = 0; m_over = 0;
    endtask

    task automatic do_start;
        gg.startGame = 1'b1;
        cyc;
        gg.startGame = 1'b0;
        model_clear();
    endtask

    // Drives one legal accepted request and checks the whole grade through the done pulse.
    task automatic do_grade(input logic [11:0] m, input logic [11:0] g, input bit scramble);
        logic [2:0] ez, ezd;
        int k = 0;
        bit seen = 0;
        model_grade(m, g, ez, ezd);
        gg.masterPattern = m; gg.guess = g; gg.masterLoaded = 1'b1; gg.gradeIt = 1'b1;
        cyc;
        gg.gradeIt = 1'b0;
        n_checks++;
        if ({gg.busy, gg.done, gg.badGuess} !== 3'b100) begin
            n_errors++;
            $display("FAIL accept: busy/done/bad got %b expected 100", {gg.busy, gg.done, gg.badGuess});
        end
        while (!seen && k < 20) begin
            if (scramble) begin
                gg.masterPattern = 12'($urandom); gg.guess = 12'($urandom);
                gg.masterLoaded = 1'($urandom_range(0, 1)); gg.gradeIt = 1'($urandom_range(0, 1));
            end
            cyc;
            k++;
            if (gg.done === 1'b1) begin
                seen = 1;
            end else begin
                n_checks++;
                if (gg.busy !== 1'b1 || gg.znarly !== m_z || gg.zood !== m_zd || gg.roundNumber !== m_round) begin
                    n_errors++;
                    $display("FAIL hold k=%0d: busy=%b zn=%0d zo=%0d rnd=%0d expected busy=1 zn=%0d zo=%0d rnd=%0d",
                             k, gg.busy, gg.znarly, gg.zood, gg.roundNumber, m_z, m_zd, m_round);
                end
            end
        end
        gg.gradeIt = 1'b0; gg.masterLoaded = 1'b1;
        n_checks++;
        if (!seen || k != 11) begin
            n_errors++;
            $display("FAIL latency: done after %0d cycles (seen=%0d) expected 11", k, seen);
        end
        m_z = ez; m_zd = ezd; m_round++;
        m_won  = (ez == 3'd4);
        m_over = m_over | m_won | (m_round == 4'd8);
        n_checks++;
        if (gg.znarly !== m_z || gg.zood !== m_zd || gg.roundNumber !== m_round ||
            gg.gameWon !== m_won || gg.gameOver !== m_over || gg.busy !== 1'b1 || gg.badGuess !== 1'b0) begin
            n_errors++;
            $display("FAIL result m=%h g=%h: zn=%0d zo=%0d rnd=%0d won=%b over=%b busy=%b bad=%b expected zn=%0d zo=%0d rnd=%0d won=%b over=%b busy=1 bad=0",
                     m, g, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver, gg.busy, gg.badGuess,
                     m_z, m_zd, m_round, m_won, m_over);
        end
    endtask

    task automatic check_idle(input string name);
        cyc;
        n_checks++;
        if ({gg.busy, gg.done, gg.badGuess} !== 3'b000) begin
            n_errors++;
            $display("FAIL %s: busy/done/bad got %b expected 000", name, {gg.busy, gg.done, gg.badGuess});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc;
        n_checks++;
        if ({gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_state: outputs got %h expected 0",
                     {gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver});
        end
        reset = 1'b0;
        model_clear();
        check_idle("after_reset");
    endtask

    task automatic test_win;
        do_start();
        do_grade(12'b001_010_011_100, 12'b001_010_011_100, 0);
        check_idle("win_done_drop");
        gg.guess = 12'b001_010_011_100; gg.gradeIt = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc;
            n_checks++;
            if (gg.busy !== 1'b0 || gg.done !== 1'b0 || gg.roundNumber !== 4'd1) begin
                n_errors++;
                $display("FAIL win_ignore: busy=%b done=%b rnd=%0d expected 0 0 1", gg.busy, gg.done, gg.roundNumber);
            end
        end
        gg.gradeIt = 1'b0;
    endtask

    task automatic test_patterns;
        do_start();
        do_grade(12'b001_010_011_100, 12'b100_011_010_001, 1);
        check_idle("perm_idle");
        do_start();
        do_grade(12'b001_001_010_010, 12'b001_010_001_011, 1);
        check_idle("dup_idle");
    endtask

    task automatic test_bad_guess;
        logic [11:0] bad [2];
        bad[0] = 12'b000_010_011_100;
        bad[1] = 12'b001_111_011_100;
        do_start();
        do_grade(12'b001_010_011_100, 12'b010_010_010_010, 0);
        check_idle("bad_pre");
        for (int i = 0; i < 2; i++) begin
            gg.guess = bad[i]; gg.gradeIt = 1'b1;
            cyc;
            gg.gradeIt = 1'b0;
            n_checks++;
            if (gg.badGuess !== 1'b1 || gg.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL bad_pulse: bad=%b busy=%b expected 1 0", gg.badGuess, gg.busy);
            end
            cyc;
            n_checks++;
            if (gg.badGuess !== 1'b0 || gg.busy !== 1'b0 || gg.roundNumber !== m_round) begin
                n_errors++;
                $display("FAIL bad_after: bad=%b busy=%b rnd=%0d expected 0 0 %0d", gg.badGuess, gg.busy, gg.roundNumber, m_round);
            end
        end
    endtask

    task automatic test_not_loaded;
        do_start();
        gg.masterLoaded = 1'b0; gg.gradeIt = 1'b1;
        gg.guess = 12'b000_001_001_001;
        check_idle("unloaded_bad");
        gg.guess = 12'b001_001_001_001;
        check_idle("unloaded_good");
        check_idle("unloaded_good2");
        gg.gradeIt = 1'b0; gg.masterLoaded = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [11:0] m = rand_legal();
        do_start();
        do_grade(m, non_winning(m), 1);
        do_grade(m, non_winning(m), 0);
        do_grade(m, m, 1);
        check_idle("b2b_idle");
    endtask

    task automatic test_max_rounds;
        logic [11:0] m = rand_legal();
        do_start();
        for (int r = 0; r < 8; r++) begin
            do_grade(m, non_winning(m), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) cyc;
        end
        n_checks++;
        if (gg.roundNumber !== 4'd8 || gg.gameOver !== 1'b1 || gg.gameWon !== 1'b0) begin
            n_errors++;
            $display("FAIL max_rounds: rnd=%0d over=%b won=%b expected 8 1 0", gg.roundNumber, gg.gameOver, gg.gameWon);
        end
        cyc;
        gg.guess = non_winning(m); gg.gradeIt = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc;
            n_checks++;
            if (gg.busy !== 1'b0 || gg.done !== 1'b0 || gg.roundNumber !== 4'd8) begin
                n_errors++;
                $display("FAIL ninth_ignored: busy=%b done=%b rnd=%0d expected 0 0 8", gg.busy, gg.done, gg.roundNumber);
            end
        end
        gg.gradeIt = 1'b0;
    endtask

    task automatic test_random;
        for (int game = 0; game < 5; game++) begin
            logic [11:0] m = rand_legal();
            int guesses = 0;
            do_start();
            while (!m_over && guesses < 12) begin
                int r = $urandom_range(0, 9);
                guesses++;
                if (r == 0) begin
                    do_grade(m, m, 1);
                end else if (r <= 2) begin
                    logic [11:0] g = rand_legal();
                    g[3*$urandom_range(0, 3) +: 3] = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
                    gg.guess = g; gg.masterPattern = m; gg.gradeIt = 1'b1;
                    cyc;
                    gg.gradeIt = 1'b0;
                    n_checks++;
                    if (gg.badGuess !== 1'b1 || gg.busy !== 1'b0 || gg.done !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rand_bad g=%h: bad=%b busy=%b done=%b expected 1 0 0", g, gg.badGuess, gg.busy, gg.done);
                    end
                end else begin
                    do_grade(m, rand_legal(), 1);
                end
                repeat ($urandom_range(0, 2)) cyc;
            end
        end
    endtask

    task automatic test_abort;
        logic [11:0] m = rand_legal();
        do_start();
        do_grade(m, non_winning(m), 0);
        check_idle("abort_pre");
        gg.masterPattern = m; gg.guess = non_winning(m); gg.gradeIt = 1'b1;
        cyc;
        gg.gradeIt = 1'b0;
        repeat (4) cyc;
        gg.startGame = 1'b1;
        cyc;
        gg.startGame = 1'b0;
        model_clear();
        n_checks++;
        if ({gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver} !== 15'd0) begin
            n_errors++;
            $display("FAIL abort_clear: outputs got %h expected 0",
                     {gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver});
        end
        for (int i = 0; i < 12; i++) check_idle("abort_no_done");
    endtask

    task automatic test_async_reset;
        logic [11:0] m = rand_legal();
        do_start();
        do_grade(m, non_winning(m), 0);
        gg.masterPattern = m; gg.guess = non_winning(m); gg.gradeIt = 1'b1;
        cyc;
        gg.gradeIt = 1'b0;
        repeat (3) cyc;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver} !== 15'd0) begin
            n_errors++;
            $display("FAIL async_reset: outputs got %h expected 0",
                     {gg.busy, gg.done, gg.badGuess, gg.znarly, gg.zood, gg.roundNumber, gg.gameWon, gg.gameOver});
        end
        cyc;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) check_idle("reset_no_done");
    endtask

    initial begin
        gg.startGame = 1'b0; gg.masterLoaded = 1'b1; gg.gradeIt = 1'b0;
        gg.masterPattern = '0; gg.guess = '0;
        model_clear();
        test_reset();
        test_win();
        test_patterns();
        test_bad_guess();
        test_not_loaded();
        test_back_to_back();
        test_max_rounds();
        test_random();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
